irq_pending_ctrl: RTL
=====================

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops per request line; legal values are 2 or 3.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low, released synchronously to clk.
REQ-004 req_in  input  4  SHALL carry asynchronous request lines; a rising edge on a line is one request.
REQ-005 mask_in  input  4  SHALL be per-line enable; 1 means the line may be offered.
REQ-006 irq_ready  input  1  SHALL be the consumer-accept signal.
REQ-007 ovr_clr  input  1  SHALL be a synchronous clear for overrun_o.
REQ-008 pend_o  output  4  SHALL be the pending vector ANDed with mask_in, feeding the downstream priority encoder.
REQ-009 irq_valid  output  1  SHALL mark an offered request.
REQ-010 irq_id  output  2  SHALL give the offered line index; line 3 is highest priority.
REQ-011 overrun_o  output  4  SHALL be sticky per-line flags for requests lost while already pending.

Function
REQ-012 Each req_in bit SHALL pass through SYNC_STAGES flops, then a one-flop rising-edge detector (sync_out=1, prev=0).
REQ-013 A detected edge SHALL set pending[i] on the same clock edge the detector sees it; with SYNC_STAGES=2 this is the 3rd rising clk edge after req_in[i] rises.
REQ-014 Edge on line i while pending[i]=1 and not being cleared that cycle SHALL set overrun_o[i]; pending is unchanged.
REQ-015 Masked lines SHALL still latch pending and overrun; masking only blocks pend_o and offer selection.
REQ-016 FSM SHALL have two states, IDLE and OFFER; irq_valid=1 exactly in OFFER (registered, no combinational path from inputs).
REQ-017 IDLE -> OFFER when (pending & mask_in) != 0; irq_id is loaded with the highest set index of that vector on the same edge.
REQ-018 In OFFER, irq_id SHALL stay stable until transfer, even if mask_in or pending changes.
REQ-019 Transfer = irq_valid && irq_ready at a rising edge; at that edge pending[irq_id] clears and FSM -> IDLE.
REQ-020 After any transfer irq_valid SHALL be low for at least one cycle; back-to-back offers are therefore 2 cycles apart.
REQ-021 New edge on line irq_id in the transfer cycle SHALL win: pending[irq_id] stays 1, no overrun flagged.
REQ-022 ovr_clr=1 SHALL clear all overrun_o bits; an overrun event on the same edge SHALL win for that bit.
REQ-023 irq_ready while irq_valid=0 SHALL have no effect.

Reset
REQ-024 On rst_n=0: synchronizer and prev flops = 0, pending = 0, overrun_o = 0, irq_id = 0, irq_valid = 0, FSM = IDLE, all immediately.
REQ-025 Reset mid-offer SHALL drop the offer with no transfer; a request held high through reset release SHALL register as exactly one new edge.

Structure
REQ-026 Package irq_pkg SHALL hold N_REQ=4, ID_W=2 and the FSM state type (IDLE=0, OFFER=1).
REQ-027 Sub-module req_sync_edge (synchronizer plus edge detector, SYNC_STAGES-parameterized, 4-bit vector) SHALL be instantiated once.
REQ-028 Priority selection SHALL be a combinational function inside irq_pending_ctrl; no other sub-modules.

Verification
REQ-029 Reset, mask=1111, req_in=0001 pulse, irq_ready=1 -> pend_o=0001 at edge 3, irq_valid=1 irq_id=00 at edge 4, transfer at edge 5, pend_o=0000 after.
REQ-030 req_in 0000->1010 same cycle, irq_ready=0 for 5 cycles then 1 -> irq_id=11 stable throughout, then irq_valid low one cycle, then irq_id=01.
REQ-031 Line 2 pending, second 0->1 edge on line 2 before service -> overrun_o=0100; ovr_clr pulse -> 0000; coincident overrun+ovr_clr -> stays 0100.
REQ-032 mask=0111, req_in=1000 edge -> pend_o=0000, irq_valid stays 0; mask->1111 -> offer irq_id=11 next cycle.
REQ-033 Offer irq_id=01 with new line-1 edge landing on the transfer edge -> pending[1] remains 1, overrun_o=0000, second offer irq_id=01.
REQ-034 rst_n low mid-offer with req_in=0100 held high -> outputs all zero asynchronously; after release one offer irq_id=10 occurs, no overrun.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared sizing and FSM state type for the interrupt pending controller.
package irq_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_t;

endpackage

// File: rtl/req_sync_edge.sv
// Purpose: synchronize async request lines and flag each 0->1 transition for one cycle.
// Latency: rise asserts SYNC_STAGES cycles after req_in rises, and is consumed on the next edge.
// Backpressure: none; rises are single-cycle strobes that downstream must latch.
module req_sync_edge
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] rise
);

  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Because the chain and prev both reset to 0, a line held high through reset
  // produces exactly one rise after release.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Purpose: latch synchronized request edges as pending bits and offer the highest masked one.
// Latency: edge->pending at the 3rd clk (SYNC_STAGES=2), pending->irq_valid one more clk.
// Backpressure: irq_valid/irq_id hold until irq_ready; edges on an already-pending line set overrun.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask_in,
  input  logic             irq_ready,
  input  logic             ovr_clr,
  output logic [N_REQ-1:0] pend_o,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_REQ-1:0] overrun_o
);

  irq_state_t       state_q;
  logic             valid_q;
  logic [ID_W-1:0]  id_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] overrun_q;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] offer_vec;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] ovr_evt;
  logic             xfer;

  function automatic logic [ID_W-1:0] prio_sel(input logic [N_REQ-1:0] v);
    logic [ID_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) sel = ID_W'(i);
    end
    return sel;
  endfunction

  req_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .rise   (rise)
  );

  assign offer_vec = pending_q & mask_in;
  assign xfer      = valid_q & irq_ready;

  always_comb begin
    clr_vec = '0;
    if (xfer) clr_vec[id_q] = 1'b1;
  end

  // A fresh edge on the line being serviced re-arms it rather than counting as lost.
  assign ovr_evt = rise & pending_q & ~clr_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | rise;
      overrun_q <= ovr_clr ? ovr_evt : (overrun_q | ovr_evt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|offer_vec) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            id_q    <= prio_sel(offer_vec);
          end
        end
        OFFER: begin
          // id_q is frozen here regardless of mask or pending changes.
          if (irq_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pend_o    = offer_vec;
  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign overrun_o = overrun_q;

endmodule
